// File: rtl/exe_result_buffer_if.sv
// exe_result_buffer_if: enqueue/dequeue/flush handshake and status between ALU, buffer and writeback
interface exe_result_buffer_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 74
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             EN_enq;
  logic [WIDTH-1:0] enq_data;
  logic             RDY_enq;
  logic             EN_deq;
  logic [WIDTH-1:0] first;
  logic             RDY_deq;
  logic             EN_flush;
  logic [CW-1:0]    count;
  logic             err_overflow;
  modport master (
    output EN_enq, enq_data, EN_deq, EN_flush,
    input  RDY_enq, first, RDY_deq, count, err_overflow
  );
  modport slave (
    input  EN_enq, enq_data, EN_deq, EN_flush,
    output RDY_enq, first, RDY_deq, count, err_overflow
  );
endinterface

// File: rtl/exe_result_buffer.sv
// exe_result_buffer: FIFO holding ALU results until the memory/writeback stage accepts them
module exe_result_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 74
) (
  input logic               CLK,
  input logic               RST_N,
  exe_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             err;
  logic             do_enq, do_deq;
  assign bus.RDY_enq      = cnt < CW'(DEPTH);
  assign bus.RDY_deq      = cnt != '0;
  assign bus.first        = mem[rd_ptr];
  assign bus.count        = cnt;
  assign bus.err_overflow = err;
  assign do_enq = bus.EN_enq & bus.RDY_enq & ~bus.EN_flush;
  assign do_deq = bus.EN_deq & bus.RDY_deq & ~bus.EN_flush;
  // storage is written only on an accepted enqueue and never reset
  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr] <= bus.enq_data;
  end
  // pointers, occupancy and sticky overflow; flush beats any concurrent traffic
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else if (bus.EN_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_enq) - CW'(do_deq);
      if (bus.EN_enq & ~bus.RDY_enq) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_exe_result_buffer.sv
// tb_exe_result_buffer: scoreboard bench for exe_result_buffer
module tb_exe_result_buffer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 74;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] q[$];
  logic m_err = 1'b0;
  exe_result_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  exe_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic post(input string tag);
    check({tag, ".count"}, WIDTH'(bus.count), WIDTH'(q.size()));
    check({tag, ".rdy_enq"}, WIDTH'(bus.RDY_enq), WIDTH'(q.size() < DEPTH));
    check({tag, ".rdy_deq"}, WIDTH'(bus.RDY_deq), WIDTH'(q.size() != 0));
    check({tag, ".err"}, WIDTH'(bus.err_overflow), WIDTH'(m_err));
    if (q.size() != 0) check({tag, ".first"}, bus.first, q[0]);
  endtask
  task automatic step(input bit enq, input logic [WIDTH-1:0] d, input bit deq, input bit fl);
    bit full;
    bit empty;
    bus.EN_enq = enq;
    bus.enq_data = d;
    bus.EN_deq = deq;
    bus.EN_flush = fl;
    full = q.size() == DEPTH;
    empty = q.size() == 0;
    if (deq && !fl && !empty) check("deq.first", bus.first, q[0]);
    if (fl) q.delete();
    else begin
      if (enq && full) m_err = 1'b1;
      if (deq && !empty) void'(q.pop_front());
      if (enq && !full) q.push_back(d);
    end
    @(posedge CLK);
    @(negedge CLK);
    bus.EN_enq = 1'b0;
    bus.EN_deq = 1'b0;
    bus.EN_flush = 1'b0;
    post("step");
  endtask
  initial begin
    bus.EN_enq = 1'b0;
    bus.enq_data = '0;
    bus.EN_deq = 1'b0;
    bus.EN_flush = 1'b0;
    repeat (2) @(negedge CLK);
    post("reset");
    RST_N = 1'b1;
    @(negedge CLK);
    for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 0, 0);
    check("fill.first", bus.first, WIDTH'(1));
    check("fill.rdy_enq", WIDTH'(bus.RDY_enq), '0);
    check("fill.count", WIDTH'(bus.count), WIDTH'(4));
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    check("drain.rdy_deq", WIDTH'(bus.RDY_deq), '0);
    check("drain.count", WIDTH'(bus.count), '0);
    step(1, WIDTH'(100), 0, 0);
    step(1, WIDTH'(101), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, WIDTH'(102 + i), 1, 0);
      check("traffic.count", WIDTH'(bus.count), WIDTH'(2));
    end
    check("traffic.first", bus.first, WIDTH'(110));
    step(1, WIDTH'(112), 0, 0);
    check("preflush.count", WIDTH'(bus.count), WIDTH'(3));
    step(1, WIDTH'('hAA), 1, 1);
    check("flush.count", WIDTH'(bus.count), '0);
    check("flush.rdy_deq", WIDTH'(bus.RDY_deq), '0);
    step(1, WIDTH'('hBB), 0, 0);
    check("flush.first", bus.first, WIDTH'('hBB));
    step(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, WIDTH'(16 + i), 0, 0);
    step(1, WIDTH'('hDEAD), 0, 0);
    check("ovf.err", WIDTH'(bus.err_overflow), WIDTH'(1));
    check("ovf.count", WIDTH'(bus.count), WIDTH'(4));
    step(1, WIDTH'('h55), 1, 0);
    check("fullboth.count", WIDTH'(bus.count), WIDTH'(3));
    step(1, WIDTH'('h66), 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    check("flush.err_sticky", WIDTH'(bus.err_overflow), WIDTH'(1));
    step(1, WIDTH'(1), 0, 0);
    step(1, WIDTH'(2), 0, 0);
    #1 RST_N = 1'b0;
    #1;
    check("arst.count", WIDTH'(bus.count), '0);
    check("arst.rdy_deq", WIDTH'(bus.RDY_deq), '0);
    check("arst.err", WIDTH'(bus.err_overflow), '0);
    q.delete();
    m_err = 1'b0;
    #1 RST_N = 1'b1;
    @(negedge CLK);
    post("arst");
    step(1, WIDTH'('h77), 0, 0);
    check("arst.first", bus.first, WIDTH'('h77));
    step(1, WIDTH'('h78), 1, 0);
    step(0, '0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
